upscale: RTL and testbench
==========================

UPSCALE -- requirements
Module: upscale

Interface
REQ-001 SHALL have parameter NUM_WIDTH, default 33, the MAC/ADD number width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 16, the image sample width in bits; NUM_WIDTH > IMG_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port shift  input  8  left-shift amount, sampled with each accepted sample.
REQ-006 SHALL have port up_valid  input  1  upstream sample valid.
REQ-007 SHALL have port up_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port up_data  input  IMG_WIDTH  signed image sample.
REQ-009 SHALL have port dn_valid  output  1  dn_data valid.
REQ-010 SHALL have port dn_ready  input  1  downstream accepts dn_data.
REQ-011 SHALL have port dn_data  output  NUM_WIDTH  signed, scaled number.
REQ-012 SHALL have port overflow  output  1  sticky flag: some accepted sample did not fit after shifting.

Function
REQ-013 SHALL compute dn_data = sign_extend(up_data, NUM_WIDTH) << shift, the inverse of the number-to-image rescale.
REQ-014 SHALL accept a sample on a cycle where up_valid && up_ready; SHALL transfer output on a cycle where dn_valid && dn_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 registers the sign-extended sample and shift; S2 registers the shifted/checked result driving dn_data.
REQ-016 SHALL have latency 2 cycles from acceptance to dn_valid with dn_ready held high; SHALL sustain 1 sample/cycle.
REQ-017 SHALL drive up_ready = !s1_valid || !s2_valid || dn_ready; no bubbles while downstream is ready.
REQ-018 SHALL hold dn_data and dn_valid stable while dn_valid && !dn_ready.
REQ-019 SHALL apply each sample's own captured shift; shift changes mid-stream SHALL NOT affect samples already in the pipeline.
REQ-020 SHALL flag a sample as out of range when x << shift is not representable as NUM_WIDTH signed (x > NUM_MAX >> shift or x < NUM_MIN >> shift).
REQ-021 SHALL treat shift >= NUM_WIDTH as: x == 0 -> result 0, in range; x != 0 -> out of range.
REQ-022 SHALL set overflow on S2 capture of an out-of-range sample; it SHALL remain set until rst.
REQ-023 SHALL treat shift == 0 as pure sign extension; never out of range.

Reset
REQ-024 SHALL, on rst, clear s1_valid, s2_valid, dn_valid and overflow, and zero dn_data, on the same clock edge.
REQ-025 SHALL discard in-flight samples on rst mid-stream; up_ready SHALL be 1 the cycle after rst deasserts.

Configuration
REQ-026 SHALL, with UPSCALE_SATURATE_EN defined, output NUM_MAX (0 followed by ones) for out-of-range positive and NUM_MIN (1 followed by zeros) for out-of-range negative samples.
REQ-027 SHALL, without UPSCALE_SATURATE_EN, output the low NUM_WIDTH bits of the shift (wrap; 0 when shift >= NUM_WIDTH); overflow flag behaves identically in both builds.

Structure
REQ-028 SHALL take NUM_MAX/NUM_MIN and IMG_MAX/IMG_MIN constant definitions from the shared filter package so that rescale and upscale agree.
REQ-029 SHALL implement the range check as a local function; no sub-module is required.

Verification (NUM_WIDTH=33, IMG_WIDTH=16)
REQ-030 SHALL cover: up_data=16'h7FFF, shift=17 -> dn_data=33'h0_FFFE_0000, overflow stays 0, dn_valid 2 cycles after accept.
REQ-031 SHALL cover: up_data=16'h7FFF, shift=18 -> SAT_EN: 33'h0_FFFF_FFFF; no SAT_EN: 33'h1_FFFC_0000; overflow=1 in both.
REQ-032 SHALL cover: up_data=16'h8000, shift=17 -> 33'h1_0000_0000 exact, no overflow; shift=18 -> SAT_EN 33'h1_0000_0000 with overflow=1.
REQ-033 SHALL cover: 8-sample burst with dn_ready toggled 1,0,0,1,... -> all 8 outputs in order, no loss or duplication, dn_data stable while stalled.
REQ-034 SHALL cover: up_data=0, shift=200 -> dn_data=0, overflow=0; then rst asserted with 2 samples in flight -> dn_valid=0, overflow=0 next cycle.

Source files
------------

// File: rtl/upscale_pkg.sv
// Shared filter constants so rescale and upscale agree on number/image ranges.
// Helpers return 64-bit patterns; callers truncate to their own width.
package upscale_pkg;

    localparam int NUM_WIDTH_DEF = 33;
    localparam int IMG_WIDTH_DEF = 16;
    localparam int SHIFT_W       = 8;

    function automatic logic [63:0] num_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] num_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] img_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] img_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/upscale.sv
// Two-stage image-to-number upscale: sign-extend then shift left with range check.
// Define UPSCALE_SATURATE_EN to clamp out-of-range results instead of wrapping.
module upscale
    import upscale_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEF,
    parameter int IMG_WIDTH = IMG_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [IMG_WIDTH-1:0] up_data,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 overflow
);

    localparam logic signed [NUM_WIDTH-1:0] NUM_MAX =
        NUM_WIDTH'(num_max(NUM_WIDTH));
    localparam logic signed [NUM_WIDTH-1:0] NUM_MIN =
        NUM_WIDTH'(num_min(NUM_WIDTH));

    // x << sh fits iff NUM_MIN>>>sh <= x <= NUM_MAX>>>sh (exact for powers of two)
    function automatic logic out_of_range(
        input logic signed [NUM_WIDTH-1:0] x,
        input logic [SHIFT_W-1:0]          sh
    );
        logic oor;
        if (32'(sh) >= 32'(NUM_WIDTH)) begin
            oor = (x != '0);
        end else begin
            oor = (x > (NUM_MAX >>> sh)) || (x < (NUM_MIN >>> sh));
        end
        return oor;
    endfunction

    logic                        s1_valid_q, s1_valid_d;
    logic signed [NUM_WIDTH-1:0] s1_x_q, s1_x_d;
    logic [SHIFT_W-1:0]          s1_sh_q, s1_sh_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [NUM_WIDTH-1:0]        s2_data_q, s2_data_d;
    logic                        ovf_q, ovf_d;

    logic                        s1_free;
    logic                        s2_free;
    logic                        s1_oor;
    logic [NUM_WIDTH-1:0]        s1_res;

    always_comb begin
        s2_free = !s2_valid_q || dn_ready;
        s1_free = !s1_valid_q || s2_free;
        s1_oor  = out_of_range(s1_x_q, s1_sh_q);
        // shift counts past the width already yield zero
        s1_res  = s1_x_q << s1_sh_q;
`ifdef UPSCALE_SATURATE_EN
        if (s1_oor) begin
            s1_res = s1_x_q[NUM_WIDTH-1] ? NUM_MIN : NUM_MAX;
        end
`endif
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_sh_d    = s1_sh_q;
        if (s1_free) begin
            s1_valid_d = up_valid;
            if (up_valid) begin
                s1_x_d  = {{(NUM_WIDTH-IMG_WIDTH){up_data[IMG_WIDTH-1]}},
                           up_data};
                s1_sh_d = shift;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        ovf_d      = ovf_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_res;
                ovf_d     = ovf_q | s1_oor;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_sh_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_sh_q    <= s1_sh_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign up_ready = s1_free;
    assign dn_valid = s2_valid_q;
    assign dn_data  = s2_data_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_upscale.sv
// Randomised and directed bench for upscale against an arithmetic reference.
// Honours UPSCALE_SATURATE_EN the same way as the design.
module tb_upscale;

`ifdef UPSCALE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [32:0] d;
        bit          o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  shift;
    logic        up_valid;
    logic        up_ready;
    logic [15:0] up_data;
    logic        dn_valid;
    logic        dn_ready;
    logic [32:0] dn_data;
    logic        overflow;

    int   checks   = 0;
    int   failures = 0;
    int   out_count = 0;
    exp_t q[$];
    bit   ovf_acc = 1'b0;
    bit   hold = 1'b0;
    logic [32:0] hold_d;

    upscale #(.NUM_WIDTH(33), .IMG_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .shift(shift),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: true product of the signed sample and 2**shift
    function automatic void model(input logic [15:0] d, input logic [7:0] sh,
                                  output logic [32:0] res, output bit oor);
        longint      x;
        longint      p;
        logic [63:0] pu;
        x = longint'($signed(d));
        if (sh >= 8'd33) begin
            oor = (x != 0);
            pu  = '0;
        end else begin
            p   = x * (longint'(1) << sh);
            oor = (p > 64'sd4294967295) || (p < -64'sd4294967296);
            pu  = p;
        end
        res = pu[32:0];
        if (SAT && oor) res = (x < 0) ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF;
    endfunction

    always @(negedge clk) begin
        logic [32:0] r;
        bit          o;
        exp_t        e;
        if (rst) begin
            q.delete();
            ovf_acc = 1'b0;
            hold    = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 64'(dn_valid), 64'd1);
                check("hold_data", 64'(dn_data), 64'(hold_d));
            end
            hold   = dn_valid && !dn_ready;
            hold_d = dn_data;
            if (dn_valid && dn_ready) begin
                out_count++;
                if (q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_data", 64'(dn_data), 64'(e.d));
                    check("sb_ovf", 64'(overflow), 64'(e.o));
                end
            end
            if (up_valid && up_ready) begin
                model(up_data, shift, r, o);
                ovf_acc = ovf_acc | o;
                q.push_back('{r, ovf_acc});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        up_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [15:0] d,
                           input logic [7:0] sh, input logic [32:0] exp_d,
                           input bit exp_o);
        int n;
        up_data = d;
        shift = sh;
        up_valid = 1'b1;
        dn_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 64'(up_ready), 64'd1);
        @(posedge clk); #1;
        up_valid = 1'b0;
        n = 0;
        while (!dn_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd2);
        check({tag, "_data"}, 64'(dn_data), 64'(exp_d));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_o));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        dn_ready = 1'b1;
        up_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_drain"}, 64'(q.size()), 64'd0);
    endtask

    task automatic rand_sample();
        case ($urandom_range(0, 3))
            0: up_data = 16'h7FFF;
            1: up_data = 16'h8000;
            default: up_data = 16'($urandom);
        endcase
        if ($urandom_range(0, 9) == 0) shift = 8'($urandom_range(0, 255));
        else shift = 8'($urandom_range(0, 34));
    endtask

    initial begin
        int base;
        int i;
        int cyc;
        bit acc;
        rst = 1'b1;
        up_valid = 1'b0;
        up_data = '0;
        shift = '0;
        dn_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dn_valid", 64'(dn_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_dn_data", 64'(dn_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_up_ready", 64'(up_ready), 64'd1);
        @(posedge clk); #1;

        run_one("max17", 16'h7FFF, 8'd17, 33'h0_FFFE_0000, 1'b0);
        do_reset();
        run_one("max18", 16'h7FFF, 8'd18,
                SAT ? 33'h0_FFFF_FFFF : 33'h1_FFFC_0000, 1'b1);
        do_reset();
        run_one("sh0", 16'h8000, 8'd0, 33'h1_FFFF_8000, 1'b0);
        run_one("min17", 16'h8000, 8'd17, 33'h1_0000_0000, 1'b0);
        run_one("neg1_32", 16'hFFFF, 8'd32, 33'h1_0000_0000, 1'b0);
        run_one("min18", 16'h8000, 8'd18,
                SAT ? 33'h1_0000_0000 : 33'h0, 1'b1);
        do_reset();
        run_one("one32", 16'h0001, 8'd32,
                SAT ? 33'h0_FFFF_FFFF : 33'h1_0000_0000, 1'b1);
        do_reset();
        run_one("zero200", 16'h0000, 8'd200, 33'h0, 1'b0);
        run_one("one33", 16'h0001, 8'd33,
                SAT ? 33'h0_FFFF_FFFF : 33'h0, 1'b1);

        do_reset();
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data = 16'h7FFF;
        shift = 8'd18;
        @(posedge clk); #1;
        up_data = 16'h0001;
        shift = 8'd1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        @(negedge clk);
        check("flight_valid", 64'(dn_valid), 64'd1);
        check("flight_ovf", 64'(overflow), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(dn_valid), 64'd0);
        check("flush_ovf", 64'(overflow), 64'd0);
        check("flush_data", 64'(dn_data), 64'd0);
        check("flush_ready", 64'(up_ready), 64'd1);
        @(posedge clk); #1;

        base = out_count;
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 100) begin
            up_valid = 1'b1;
            rand_sample();
            dn_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            acc = up_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        check("burst_accepts", 64'(i), 64'd8);
        drain("burst");
        check("burst_outs", 64'(out_count - base), 64'd8);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            up_valid = 1'($urandom_range(0, 3) != 0);
            rand_sample();
            dn_ready = 1'($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
